// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the signals around the shared single-port data RAM: the MEM-stage
// request, the DMA/debug-loader request and the RAM port itself.
//   slave  : the arbiter side (takes both requests, drives grants and RAM port)
//   master : the surrounding logic (pipeline, DMA engine, RAM instance)
// Signal names keep the original block port names so the hookup into
// MEMORY_STAGE and the hazard unit stays one-to-one.
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
);
    // MEM pipeline stage request
    logic                     i_PipeReqM;
    logic [ADDRESS_WIDTH-1:0] i_PipeAddrM;
    logic [DATA_WIDTH-1:0]    i_PipeWDataM;
    logic                     i_PipeWEnM;
    logic [1:0]               i_PipeSelM;
    // DMA / debug-loader request
    logic                     i_DmaReq;
    logic [ADDRESS_WIDTH-1:0] i_DmaAddr;
    logic [DATA_WIDTH-1:0]    i_DmaWData;
    logic                     i_DmaWEn;
    logic [1:0]               i_DmaSel;
    logic                     o_DmaGnt;
    logic [DATA_WIDTH-1:0]    o_DmaRData;
    logic                     o_DmaRValid;
    // Hazard unit
    logic                     o_StallM;
    // RAM port
    logic [ADDRESS_WIDTH-1:0] o_RamAddr;
    logic [DATA_WIDTH-1:0]    o_RamData;
    logic                     o_RamWEn;
    logic [1:0]               o_RamSel;
    logic [DATA_WIDTH-1:0]    i_RamRData;

    modport slave (
        input  i_PipeReqM, i_PipeAddrM, i_PipeWDataM, i_PipeWEnM, i_PipeSelM,
        input  i_DmaReq, i_DmaAddr, i_DmaWData, i_DmaWEn, i_DmaSel,
        output o_DmaGnt, o_DmaRData, o_DmaRValid,
        output o_StallM,
        output o_RamAddr, o_RamData, o_RamWEn, o_RamSel,
        input  i_RamRData
    );

    modport master (
        output i_PipeReqM, i_PipeAddrM, i_PipeWDataM, i_PipeWEnM, i_PipeSelM,
        output i_DmaReq, i_DmaAddr, i_DmaWData, i_DmaWEn, i_DmaSel,
        input  o_DmaGnt, o_DmaRData, o_DmaRValid,
        input  o_StallM,
        input  o_RamAddr, o_RamData, o_RamWEn, o_RamSel,
        output i_RamRData
    );
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data RAM between the MEM pipeline stage and a
// DMA/debug-loader port. The pipeline normally wins; after STARVE_LIMIT
// consecutive denied DMA cycles a DMA burst of at most BURST_MAX grants is
// forced, during which o_StallM holds the MEM stage.
// Ports:
//   i_CLK    : clock, all state on rising edge
//   i_RST_n  : asynchronous active-low reset
//   bus      : dmem_arbiter_if.slave (requests, grants, RAM port, stall)
// Grants, stall and the RAM mux are combinational because the RAM reads
// combinationally and every grant completes in one cycle; only the DMA read
// return (o_DmaRData / o_DmaRValid) is registered.
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int STARVE_LIMIT  = 4,
    parameter int BURST_MAX     = 4
) (
    input  logic           i_CLK,
    input  logic           i_RST_n,
    dmem_arbiter_if.slave  bus
);
    localparam int WAIT_W  = $clog2(STARVE_LIMIT + 1);
    localparam int BURST_W = $clog2(BURST_MAX + 1);

    localparam logic [WAIT_W-1:0]  WAIT_SAT   = WAIT_W'(STARVE_LIMIT);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(STARVE_LIMIT - 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_MAX - 1);

    typedef enum logic [0:0] {
        S_PIPE = 1'b0,
        S_DMA  = 1'b1
    } state_t;

    state_t               state_r;
    logic [WAIT_W-1:0]    wait_cnt_r;
    logic [BURST_W-1:0]   burst_cnt_r;
    logic [DATA_WIDTH-1:0] dma_rdata_r;
    logic                 dma_rvalid_r;

    logic pipe_gnt_s;
    logic dma_gnt_s;

    // Grant decision for the current cycle.
    always_comb begin
        pipe_gnt_s = 1'b0;
        dma_gnt_s  = 1'b0;
        case (state_r)
            S_PIPE: begin
                pipe_gnt_s = bus.i_PipeReqM;
                dma_gnt_s  = bus.i_DmaReq & ~bus.i_PipeReqM;
            end
            S_DMA: begin
                if (bus.i_DmaReq) begin
                    dma_gnt_s  = 1'b1;
                    pipe_gnt_s = 1'b0;
                end else begin
                    // Burst ends early; the slot goes back to the pipeline.
                    dma_gnt_s  = 1'b0;
                    pipe_gnt_s = bus.i_PipeReqM;
                end
            end
            default: begin
                pipe_gnt_s = bus.i_PipeReqM;
                dma_gnt_s  = 1'b0;
            end
        endcase
    end

    // RAM port mux: follows the single granted requester, idle bus otherwise.
    always_comb begin
        bus.o_RamAddr = '0;
        bus.o_RamData = '0;
        bus.o_RamWEn  = 1'b0;
        bus.o_RamSel  = 2'b00;
        if (dma_gnt_s) begin
            bus.o_RamAddr = bus.i_DmaAddr;
            bus.o_RamData = bus.i_DmaWData;
            bus.o_RamWEn  = bus.i_DmaWEn;
            bus.o_RamSel  = bus.i_DmaSel;
        end else if (pipe_gnt_s) begin
            bus.o_RamAddr = bus.i_PipeAddrM;
            bus.o_RamData = bus.i_PipeWDataM;
            bus.o_RamWEn  = bus.i_PipeWEnM;
            bus.o_RamSel  = bus.i_PipeSelM;
        end else begin
            bus.o_RamWEn  = 1'b0;
        end
    end

    assign bus.o_DmaGnt    = dma_gnt_s;
    assign bus.o_StallM    = bus.i_PipeReqM & ~pipe_gnt_s;
    assign bus.o_DmaRData  = dma_rdata_r;
    assign bus.o_DmaRValid = dma_rvalid_r;

    // Arbitration FSM with starvation and burst counters.
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_r     <= S_PIPE;
            wait_cnt_r  <= '0;
            burst_cnt_r <= '0;
        end else begin
            case (state_r)
                S_PIPE: begin
                    if (bus.i_DmaReq && bus.i_PipeReqM) begin
                        if (wait_cnt_r == WAIT_LAST) begin
                            state_r     <= S_DMA;
                            wait_cnt_r  <= '0;
                            burst_cnt_r <= '0;
                        end else if (wait_cnt_r != WAIT_SAT) begin
                            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                        end else begin
                            wait_cnt_r <= wait_cnt_r;
                        end
                    end else begin
                        // DMA was served in the idle slot, or is not asking.
                        wait_cnt_r <= '0;
                    end
                end
                S_DMA: begin
                    wait_cnt_r <= '0;
                    if (bus.i_DmaReq) begin
                        burst_cnt_r <= burst_cnt_r + BURST_W'(1);
                        if (burst_cnt_r == BURST_LAST) begin
                            state_r <= S_PIPE;
                        end else begin
                            state_r <= S_DMA;
                        end
                    end else begin
                        state_r <= S_PIPE;
                    end
                end
                default: begin
                    state_r     <= S_PIPE;
                    wait_cnt_r  <= '0;
                    burst_cnt_r <= '0;
                end
            endcase
        end
    end

    // DMA read return: capture RAM data one cycle after a DMA read grant.
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            dma_rdata_r  <= '0;
            dma_rvalid_r <= 1'b0;
        end else if (dma_gnt_s && !bus.i_DmaWEn) begin
            dma_rdata_r  <= bus.i_RamRData;
            dma_rvalid_r <= 1'b1;
        end else begin
            dma_rvalid_r <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter (STARVE_LIMIT=4, BURST_MAX=4) with a small
// word RAM model on the RAM port. Inputs change 1 time unit after the rising
// edge; outputs are sampled mid-cycle.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;
    logic clk;
    logic rst_n;

    int n_tests;
    int n_fail;

    logic [31:0] mem [0:63];

    dmem_arbiter_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus ();

    dmem_arbiter #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .STARVE_LIMIT(4), .BURST_MAX(4)
    ) dut (
        .i_CLK   (clk),
        .i_RST_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: combinational read, write on rising edge.
    assign bus.i_RamRData = mem[bus.o_RamAddr[7:2]];
    always @(posedge clk) begin
        if (bus.o_RamWEn) mem[bus.o_RamAddr[7:2]] <= bus.o_RamData;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic preq, input logic [31:0] paddr, input logic [31:0] pwdata,
                         input logic pwen, input logic dreq, input logic [31:0] daddr,
                         input logic dwen);
        bus.i_PipeReqM   = preq;
        bus.i_PipeAddrM  = paddr;
        bus.i_PipeWDataM = pwdata;
        bus.i_PipeWEnM   = pwen;
        bus.i_PipeSelM   = 2'b10;
        bus.i_DmaReq     = dreq;
        bus.i_DmaAddr    = daddr;
        bus.i_DmaWData   = 32'h0000_0000;
        bus.i_DmaWEn     = dwen;
        bus.i_DmaSel     = 2'b10;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0000;
        mem[8] = 32'h1234_5678;   // DMA read target @0x20
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Reset state
        #12;
        check_val("rst_rvalid", {31'd0, bus.o_DmaRValid}, 32'd0);
        check_val("rst_rdata",  bus.o_DmaRData, 32'd0);
        check_val("rst_stall",  {31'd0, bus.o_StallM}, 32'd0);
        check_val("rst_gnt",    {31'd0, bus.o_DmaGnt}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Pipe store 0xDEADBEEF @0x10, DMA idle
        drive(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 1'b0);
        #4;
        check_val("st_wen",   {31'd0, bus.o_RamWEn}, 32'd1);
        check_val("st_addr",  bus.o_RamAddr, 32'h10);
        check_val("st_data",  bus.o_RamData, 32'hDEAD_BEEF);
        check_val("st_stall", {31'd0, bus.o_StallM}, 32'd0);
        next_cycle();
        // Pipe load readback
        drive(1'b1, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        #4;
        check_val("ld_wen",  {31'd0, bus.o_RamWEn}, 32'd0);
        check_val("ld_data", bus.i_RamRData, 32'hDEAD_BEEF);
        next_cycle();

        // Pipe idle, DMA read @0x10 in cycle N
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h10, 1'b0);
        #4;
        check_val("dr_gnt",    {31'd0, bus.o_DmaGnt}, 32'd1);
        check_val("dr_addr",   bus.o_RamAddr, 32'h10);
        check_val("dr_rv_n",   {31'd0, bus.o_DmaRValid}, 32'd0);
        next_cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        #4;
        check_val("dr_rv_n1",  {31'd0, bus.o_DmaRValid}, 32'd1);
        check_val("dr_rd_n1",  bus.o_DmaRData, 32'hDEAD_BEEF);
        check_val("dr_idle_addr", bus.o_RamAddr, 32'h0);
        next_cycle();
        #4;
        check_val("dr_rv_n2",  {31'd0, bus.o_DmaRValid}, 32'd0);
        check_val("dr_rd_hold", bus.o_DmaRData, 32'hDEAD_BEEF);
        next_cycle();

        // Both request continuously: pipe 0-3, DMA 4-7, pipe from 8
        for (int c = 0; c < 10; c++) begin
            logic dma_exp;
            dma_exp = (c >= 4) && (c <= 7);
            drive(1'b1, 32'h10, 32'h0, 1'b0, 1'b1, 32'h20, 1'b0);
            #4;
            check_val($sformatf("t4_gnt%0d", c),   {31'd0, bus.o_DmaGnt}, {31'd0, dma_exp});
            check_val($sformatf("t4_stall%0d", c), {31'd0, bus.o_StallM}, {31'd0, dma_exp});
            check_val($sformatf("t4_addr%0d", c),  bus.o_RamAddr, dma_exp ? 32'h20 : 32'h10);
            check_val($sformatf("t4_rv%0d", c),    {31'd0, bus.o_DmaRValid},
                      {31'd0, (c >= 5) && (c <= 8)});
            next_cycle();
        end
        check_val("t4_rdata", bus.o_DmaRData, 32'h1234_5678);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        next_cycle();

        // DMA drops in cycle 5 of a forced burst; counter restarts from 0
        for (int c = 0; c < 12; c++) begin
            logic dma_exp;
            dma_exp = (c == 4) || (c >= 10);
            drive(1'b1, 32'h10, 32'h0, 1'b0, (c != 5), 32'h20, 1'b0);
            #4;
            check_val($sformatf("t5_gnt%0d", c),   {31'd0, bus.o_DmaGnt}, {31'd0, dma_exp});
            check_val($sformatf("t5_stall%0d", c), {31'd0, bus.o_StallM}, {31'd0, dma_exp});
            next_cycle();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        next_cycle();

        // Alternating pipe request, DMA held: DMA takes every idle slot
        for (int c = 0; c < 12; c++) begin
            logic preq;
            preq = (c % 2 == 0);
            drive(preq, 32'h10, 32'h0, 1'b0, 1'b1, 32'h20, 1'b0);
            #4;
            check_val($sformatf("t6_gnt%0d", c),   {31'd0, bus.o_DmaGnt}, {31'd0, ~preq});
            check_val($sformatf("t6_stall%0d", c), {31'd0, bus.o_StallM}, 32'd0);
            next_cycle();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        next_cycle();

        // Reset during cycle 5 of a forced burst
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 32'h10, 32'h0, 1'b0, 1'b1, 32'h20, 1'b0);
            next_cycle();
        end
        drive(1'b1, 32'h10, 32'h0, 1'b0, 1'b1, 32'h20, 1'b0);
        #1;
        check_val("t1_pre_stall", {31'd0, bus.o_StallM}, 32'd1);
        check_val("t1_pre_rv",    {31'd0, bus.o_DmaRValid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("t1_stall", {31'd0, bus.o_StallM}, 32'd0);
        check_val("t1_rv",    {31'd0, bus.o_DmaRValid}, 32'd0);
        check_val("t1_gnt",   {31'd0, bus.o_DmaGnt}, 32'd0);
        check_val("t1_addr",  bus.o_RamAddr, 32'h10);
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 32'h10, 32'h0, 1'b0, 1'b1, 32'h20, 1'b0);
            #4;
            check_val($sformatf("t1_post_gnt%0d", c), {31'd0, bus.o_DmaGnt}, {31'd0, c >= 4});
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
